// File: rtl/excess3_to_bcd_packer.sv
// Serial excess-3 to packed-BCD decoder. Digits arrive most significant first and are
// collected into a DIGITS-nibble word. Each invalid code is stored as zero and flagged.
module excess3_to_bcd_packer #(
  parameter int DIGITS = 4,
  parameter int ERR_W  = 8,
  localparam int CNT_W = $clog2(DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_digit,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic [DIGITS-1:0]     out_err_mask,
  output logic                  out_err,
  output logic [ERR_W-1:0]      err_cnt,
  output logic                  dbg_state,
  output logic [CNT_W-1:0]      dbg_cnt
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both high;
  // ready depends only on the registered state, and valid never waits on ready.
  typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [4*DIGITS-1:0] word_q, word_d;
  logic [DIGITS-1:0]   mask_q, mask_d;
  logic [ERR_W-1:0]    err_cnt_q, err_cnt_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic                out_err_q, out_err_d;
  logic                digit_ok;
  logic [3:0]          digit_bcd;

  assign digit_ok  = (in_digit >= 4'd3) && (in_digit <= 4'd12);
  assign digit_bcd = digit_ok ? (in_digit - 4'd3) : 4'd0;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    word_d    = word_q;
    mask_d    = mask_q;
    err_cnt_d = err_cnt_q;
    if (clr) begin
      state_d = COLLECT;
      cnt_d   = '0;
      word_d  = '0;
      mask_d  = '0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (in_valid) begin
            // Shift in from the LS side so the first digit ends in the top nibble.
            word_d = {word_q[4*DIGITS-5:0], digit_bcd};
            mask_d = {mask_q[DIGITS-2:0], ~digit_ok};
            if (!digit_ok && (err_cnt_q != {ERR_W{1'b1}}))
              err_cnt_d = err_cnt_q + ERR_W'(1);
            if (cnt_q == CNT_W'(DIGITS - 1)) begin
              state_d = HOLD;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) state_d = COLLECT;
        end
        default: state_d = COLLECT;
      endcase
    end
    in_ready_d  = (state_d == COLLECT);
    out_valid_d = (state_d == HOLD);
    out_err_d   = |mask_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= COLLECT;
      cnt_q       <= '0;
      word_q      <= '0;
      mask_q      <= '0;
      err_cnt_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      word_q      <= word_d;
      mask_q      <= mask_d;
      err_cnt_q   <= err_cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_err_q   <= out_err_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_bcd      = word_q;
  assign out_err_mask = mask_q;
  assign out_err      = out_err_q;
  assign err_cnt      = err_cnt_q;
  assign dbg_state    = state_q;
  assign dbg_cnt      = cnt_q;

endmodule

// File: tb/tb_excess3_to_bcd_packer.sv
// Bench for excess3_to_bcd_packer: directed cases followed by randomized traffic
// checked against an arithmetic reference model and an expected-word queue.
module tb_excess3_to_bcd_packer;

  localparam int DIGITS = 4;
  localparam int ERR_W  = 8;
  localparam int ERR_MAX = 255;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_digit;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_bcd;
  logic [3:0]  out_err_mask;
  logic        out_err;
  logic [7:0]  err_cnt;
  logic        dbg_state;
  logic [1:0]  dbg_cnt;

  int total = 0;
  int bad   = 0;
  int err_m = 0;
  int rx    = 0;
  logic [19:0] exp_q[$];

  excess3_to_bcd_packer #(.DIGITS(DIGITS), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_digit(in_digit),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_bcd(out_bcd), .out_err_mask(out_err_mask), .out_err(out_err),
    .err_cnt(err_cnt), .dbg_state(dbg_state), .dbg_cnt(dbg_cnt)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit code_ok(input logic [3:0] d);
    return (d >= 3) && (d <= 12);
  endfunction

  // Expected {mask, bcd} of a word given its digits, first received first.
  function automatic logic [19:0] model_word(input logic [3:0] d0, input logic [3:0] d1,
                                             input logic [3:0] d2, input logic [3:0] d3);
    int bcd = 0;
    int mask = 0;
    logic [3:0] ds[4];
    ds[0] = d0; ds[1] = d1; ds[2] = d2; ds[3] = d3;
    for (int i = 0; i < 4; i++) begin
      bcd  = bcd * 16 + (code_ok(ds[i]) ? int'(ds[i]) - 3 : 0);
      mask = mask * 2 + (code_ok(ds[i]) ? 0 : 1);
    end
    return {mask[3:0], bcd[15:0]};
  endfunction

  // ---------------- drivers ----------------
  task automatic send_digit(input logic [3:0] d);
    int w = 0;
    in_valid = 1'b1;
    in_digit = d;
    while (!in_ready && w < 200) begin
      tick();
      w++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
    end else begin
      tick();
      if (!code_ok(d) && err_m < ERR_MAX) err_m++;
    end
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [3:0] d0, input logic [3:0] d1,
                           input logic [3:0] d2, input logic [3:0] d3);
    send_digit(d0); send_digit(d1); send_digit(d2); send_digit(d3);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_bcd"}, out_bcd, 0);
    check({tag, "_mask"}, out_err_mask, 0);
    check({tag, "_out_err"}, out_err, 0);
    check({tag, "_err_cnt"}, err_cnt, 0);
    check({tag, "_cnt"}, dbg_cnt, 0);
  endtask

  task automatic random_driver();
    logic [3:0] d[4];
    for (int n = 0; n < 1000; n++) begin
      for (int i = 0; i < 4; i++) d[i] = 4'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++) begin
        repeat ($urandom_range(0, 2)) tick();
        if (i == 3) exp_q.push_back(model_word(d[0], d[1], d[2], d[3]));
        send_digit(d[i]);
      end
    end
  endtask

  task automatic random_monitor();
    logic [19:0] e;
    for (int c = 0; c < 60000 && rx < 1000; c++) begin
      out_ready = 1'($urandom_range(0, 1));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("rnd_unexpected_word", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("rnd_bcd", out_bcd, e[15:0]);
          check("rnd_mask", out_err_mask, e[19:16]);
          check("rnd_err", out_err, |e[19:16]);
        end
        rx++;
      end
      tick();
    end
    out_ready = 1'b0;
    check("rnd_word_count", rx, 1000);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [15:0] held;
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_digit = 4'h0; out_ready = 1'b0;
    #23;
    check_reset_values("reset");
    tick();
    rst_n = 1'b1;
    tick();

    // Basic word with out_ready held high.
    out_ready = 1'b1;
    send_word(4'h4, 4'h5, 4'h6, 4'h7);
    check("w1_valid", out_valid, 1);
    check("w1_in_ready", in_ready, 0);
    check("w1_bcd", out_bcd, 16'h1234);
    check("w1_mask", out_err_mask, 0);
    tick();
    check("w1_valid_one_cycle", out_valid, 0);

    // Mixed valid/invalid codes.
    send_word(4'h3, 4'hC, 4'h0, 4'hF);
    check("w2_bcd", out_bcd, 16'h0900);
    check("w2_mask", out_err_mask, 4'b0011);
    check("w2_err", out_err, 1);
    check("w2_err_cnt", err_cnt, err_m);
    check("w2_err_cnt_abs", err_cnt, 2);
    tick();

    // Back-pressure: word stays put and offered digits are not absorbed.
    out_ready = 1'b0;
    send_word(4'h8, 4'h9, 4'hA, 4'hB);
    held = out_bcd;
    check("hold_bcd_first", held, 16'h5678);
    in_valid = 1'b1;
    in_digit = 4'hE;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_bcd", out_bcd, 16'h5678);
      check("hold_in_ready", in_ready, 0);
      check("hold_valid", out_valid, 1);
    end
    check("hold_err_cnt", err_cnt, err_m);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("hold_released", out_valid, 0);
    send_word(4'h4, 4'h4, 4'h4, 4'h4);
    check("after_hold_bcd", out_bcd, 16'h1111);
    check("after_hold_mask", out_err_mask, 0);
    tick();

    // Abort a partial word; the digit offered with clr is dropped.
    send_digit(4'h3);
    send_digit(4'h4);
    check("pre_clr_cnt", dbg_cnt, 2);
    clr = 1'b1; in_valid = 1'b1; in_digit = 4'hE;
    tick();
    clr = 1'b0; in_valid = 1'b0;
    check("clr_err_cnt", err_cnt, err_m);
    check("clr_cnt", dbg_cnt, 0);
    check("clr_bcd", out_bcd, 0);
    check("clr_in_ready", in_ready, 1);
    send_word(4'h3, 4'h3, 4'h3, 4'hC);
    check("post_clr_bcd", out_bcd, 16'h0009);
    check("post_clr_mask", out_err_mask, 0);
    tick();

    // Saturation of the error counter.
    for (int i = 0; i < 300; i++) send_digit(4'h0);
    check("sat_err_cnt", err_cnt, ERR_MAX);
    check("sat_err_model", err_m, ERR_MAX);
    tick();
    send_digit(4'h5);
    send_digit(4'h6);
    #2;
    rst_n = 1'b0;
    #2;
    check_reset_values("midword_reset");
    tick();
    rst_n = 1'b1;
    err_m = 0;
    tick();
    check("post_reset_valid", out_valid, 0);

    // Randomized traffic.
    fork
      random_driver();
      random_monitor();
    join
    check("rnd_err_cnt", err_cnt, err_m);
    check("rnd_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
